// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO, baud divider and framing FSM in one block.
// Characters go out LSB first with optional parity and 1 or 2 stop bits; writes while full are dropped and set overrun.
module uart_tx_param #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 UART_wr,
  output logic                 full,
  output logic                 TE,
  output logic                 busy,
  output logic                 overrun,
  output logic                 TxD
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        rd_ptr, wr_ptr;
  logic [AW:0]          count;
  logic                 empty, wr_ok, pop, tick;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift, shift_nxt, head;
  logic                 par_bit, par_nxt, tx_nxt;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign wr_ok = UART_wr && !full;
  assign head  = mem[rd_ptr];
  assign tick  = (baud_cnt == CW'(CLK_DIV - 1));
  assign busy  = (state != S_IDLE);
  assign TE    = empty && (state == S_IDLE);

  // full is the pre-pop value, so a write racing a pop from a full FIFO is still refused
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !pop)      count <= count + 1'b1;
      else if (pop && !wr_ok) count <= count - 1'b1;
      if (UART_wr && full) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !reset) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      TxD      <= 1'b1;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      par_bit <= par_nxt;
      TxD     <= tx_nxt;
      if (pop || state == S_IDLE || tick) baud_cnt <= '0;
      else                                baud_cnt <= baud_cnt + 1'b1;
      if (pop)
        bit_cnt <= '0;
      else if (tick && (state == S_DATA || state == S_STOP))
        bit_cnt <= (state_nxt != state) ? '0 : bit_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: if (tick) state_nxt = S_DATA;
      S_DATA: begin
        if (tick && bit_cnt == BW'(DATA_BITS - 1))
          state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (tick) state_nxt = S_STOP;
      S_STOP: begin
        if (tick && bit_cnt == BW'(STOP_BITS - 1)) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // TxD is registered from the next-state view so it changes on the same edge as the state
  always_comb begin
    shift_nxt = shift;
    par_nxt   = par_bit;
    if (pop) begin
      shift_nxt = head;
      par_nxt   = (PARITY == 1) ? ~^head : ^head;
    end else if (state == S_DATA && tick) begin
      shift_nxt = shift >> 1;
    end
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shift_nxt[0];
      S_PARITY: tx_nxt = par_nxt;
      default:  tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations share one stimulus stream and are
// checked every cycle against a frame-level model of the FIFO and serial line.
module tb_uart_tx_param;

  logic       clk;
  logic       reset;
  logic       uart_wr;
  logic [7:0] din;
  logic [2:0] full_o, te, busy_o, ovr, txd;

  localparam int NB [3] = '{8, 7, 8};
  localparam int PB [3] = '{0, 2, 1};
  localparam int SB [3] = '{1, 2, 1};
  localparam int CD [3] = '{4, 4, 3};
  localparam int FD [3] = '{4, 4, 2};

  logic [7:0] fq   [3][4];
  int         fcnt [3];
  logic       wave [3][64];
  int         wlen [3];
  int         wpos [3];
  logic       movr [3];

  int n_tests, n_fail;

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .din(din), .UART_wr(uart_wr), .full(full_o[0]),
    .TE(te[0]), .busy(busy_o[0]), .overrun(ovr[0]), .TxD(txd[0]));

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .din(din[6:0]), .UART_wr(uart_wr), .full(full_o[1]),
    .TE(te[1]), .busy(busy_o[1]), .overrun(ovr[1]), .TxD(txd[1]));

  uart_tx_param #(.CLK_DIV(3), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)) dut_c (
    .clk(clk), .reset(reset), .din(din), .UART_wr(uart_wr), .full(full_o[2]),
    .TE(te[2]), .busy(busy_o[2]), .overrun(ovr[2]), .TxD(txd[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge of the line model: the frame in flight advances a cycle, a finished
  // frame is replaced by the FIFO head, and the write is judged against the pre-edge fill.
  task automatic model_step(input int i, input logic wr, input logic [7:0] d, input logic rst);
    logic       was_full, had;
    logic [7:0] c, m;
    logic       seq [12];
    int         n, ones;
    if (rst) begin
      fcnt[i] = 0; wlen[i] = 0; wpos[i] = 0; movr[i] = 1'b0;
      return;
    end
    was_full = (fcnt[i] == FD[i]);
    had      = (fcnt[i] > 0);
    if (wpos[i] < wlen[i]) wpos[i]++;
    if (wpos[i] >= wlen[i] && had) begin
      c = fq[i][0];
      for (int k = 0; k < 3; k++) fq[i][k] = fq[i][k+1];
      fcnt[i]--;
      n = 0;
      seq[n] = 1'b0; n++;
      for (int b = 0; b < NB[i]; b++) begin seq[n] = c[b]; n++; end
      if (PB[i] != 0) begin
        ones = $countones(c);
        seq[n] = (PB[i] == 2) ? ones[0] : ~ones[0];
        n++;
      end
      for (int s = 0; s < SB[i]; s++) begin seq[n] = 1'b1; n++; end
      wlen[i] = n * CD[i];
      wpos[i] = 0;
      for (int k = 0; k < wlen[i]; k++) wave[i][k] = seq[k / CD[i]];
    end
    if (wr) begin
      if (was_full) movr[i] = 1'b1;
      else begin
        m = 8'((1 << NB[i]) - 1);
        fq[i][fcnt[i]] = d & m;
        fcnt[i]++;
      end
    end
  endtask

  task automatic step(input logic wr, input logic [7:0] d, input logic rst);
    uart_wr = wr;
    din     = d;
    reset   = rst;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i, wr, d, rst);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      logic act;
      act = (wpos[i] < wlen[i]);
      chk($sformatf("txd%0d", i),  32'(txd[i]),    32'(act ? wave[i][wpos[i]] : 1'b1));
      chk($sformatf("te%0d", i),   32'(te[i]),     32'(!act && fcnt[i] == 0));
      chk($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(act));
      chk($sformatf("full%0d", i), 32'(full_o[i]), 32'(fcnt[i] == FD[i]));
      chk($sformatf("ovr%0d", i),  32'(ovr[i]),    32'(movr[i]));
    end
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (te != 3'b111 && n < max) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("idle_reached", 32'(te), 32'(3'b111));
  endtask

  initial begin
    logic [9:0] cap;
    int nb, first, last, lows, n, cyc;
    n_tests = 0; n_fail = 0;
    uart_wr = 1'b0; din = 8'h00; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fcnt[i] = 0; wlen[i] = 0; wpos[i] = 0; movr[i] = 1'b0;
    end

    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("rst_txd",  32'(txd),    32'(3'b111));
    chk("rst_te",   32'(te),     32'(3'b111));
    chk("rst_busy", 32'(busy_o), 32'(3'b000));
    chk("rst_full", 32'(full_o), 32'(3'b000));
    chk("rst_ovr",  32'(ovr),    32'(3'b000));

    // 8N1 frame of 0x55, sampled once per bit
    step(1'b1, 8'h55, 1'b0);
    cap = '0;
    for (int j = 0; j < 40; j++) begin
      step(1'b0, 8'h00, 1'b0);
      if (j % 4 == 0) cap[j/4] = txd[0];
      if (j == 39) chk("a_te_last_stop", 32'(te[0]), 32'(1'b0));
    end
    chk("a_55_bits", 32'(cap), 32'(10'b1010101010));
    step(1'b0, 8'h00, 1'b0);
    chk("a_te_end", 32'(te[0]), 32'(1'b1));
    wait_idle(200);

    // 7E2 frame length
    step(1'b1, 8'h07, 1'b0);
    nb = 0; n = 0;
    while (!(nb > 0 && !busy_o[1]) && n < 100) begin
      step(1'b0, 8'h00, 1'b0);
      if (busy_o[1]) nb++;
      n++;
    end
    chk("b_len", 32'(nb), 32'(44));
    wait_idle(200);

    // odd parity on dut_c: parity cell spans cycles 27..29 after the pop
    step(1'b1, 8'h03, 1'b0);
    for (int j = 0; j < 30; j++) begin
      step(1'b0, 8'h00, 1'b0);
      if (j == 28) chk("c_par03", 32'(txd[2]), 32'(1'b1));
    end
    wait_idle(200);
    step(1'b1, 8'h01, 1'b0);
    for (int j = 0; j < 30; j++) begin
      step(1'b0, 8'h00, 1'b0);
      if (j == 28) chk("c_par01", 32'(txd[2]), 32'(1'b0));
    end
    wait_idle(200);

    // six writes back to back from idle
    nb = 0; first = -1; last = -1; cyc = 0;
    for (int j = 0; j < 6; j++) begin
      step(1'b1, 8'($urandom), 1'b0);
      if (busy_o[0]) begin nb++; if (first < 0) first = cyc; last = cyc; end
      if (j == 3) chk("a_full_4th", 32'(full_o[0]), 32'(1'b0));
      if (j == 4) chk("a_full_5th", 32'(full_o[0]), 32'(1'b1));
      cyc++;
    end
    chk("a_burst_ovr", 32'(ovr[0]), 32'(1'b1));
    while (te != 3'b111 && cyc < 400) begin
      step(1'b0, 8'h00, 1'b0);
      if (busy_o[0]) begin nb++; if (first < 0) first = cyc; last = cyc; end
      cyc++;
    end
    chk("a_first_pop", 32'(first), 32'(1));
    chk("a_burst_busy", 32'(nb), 32'(200));
    chk("a_burst_span", 32'(last - first + 1), 32'(200));
    wait_idle(100);

    // write while full on the edge of a STOP->START pop
    step(1'b0, 8'h00, 1'b1);
    for (int j = 0; j < 5; j++) step(1'b1, 8'($urandom), 1'b0);
    chk("a_full_pre", 32'(full_o[0]), 32'(1'b1));
    n = 0;
    while (!(wpos[0] == wlen[0] - 1 && fcnt[0] == 4) && n < 200) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("a_stop_wait", 32'(n < 200), 32'(1'b1));
    chk("a_ovr_pre", 32'(ovr[0]), 32'(1'b0));
    step(1'b1, 8'hAA, 1'b0);
    chk("a_ovr_stoppop", 32'(ovr[0]), 32'(1'b1));
    chk("a_full_after_pop", 32'(full_o[0]), 32'(1'b0));
    chk("a_txd_start", 32'(txd[0]), 32'(1'b0));
    wait_idle(1000);

    // reset in the middle of DATA with two characters queued
    step(1'b0, 8'h00, 1'b1);
    for (int j = 0; j < 3; j++) step(1'b1, 8'($urandom), 1'b0);
    n = 0;
    while (wpos[0] < 8 && n < 50) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    step(1'b0, 8'h00, 1'b1);
    chk("rm_txd",  32'(txd[0]),    32'(1'b1));
    chk("rm_te",   32'(te[0]),     32'(1'b1));
    chk("rm_full", 32'(full_o[0]), 32'(1'b0));
    chk("rm_ovr",  32'(ovr[0]),    32'(1'b0));
    lows = 0;
    for (int j = 0; j < 60; j++) begin
      step(1'b0, 8'h00, 1'b0);
      if (!txd[0]) lows++;
    end
    chk("rm_quiet", 32'(lows), 32'(0));

    // random traffic with occasional resets
    for (int j = 0; j < 3000; j++) begin
      step($urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 599) == 0);
    end
    wait_idle(1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
